// File: rtl/interval_timer_sched.sv
// Interval timer scheduler: four programmable second-interval slots, IDLE/RUN/EXPIRE countdown FSM.
// Optional macro WALK_SLOT_EN implements slot 3 (walk); otherwise selector 3 aliases slot 0 and writes to it are dropped.
module interval_timer_sched #(
   parameter int TICK_DIV = 50000000,
   parameter int DEF_BASE = 6,
   parameter int DEF_EXT  = 3,
   parameter int DEF_YEL  = 2,
   parameter int DEF_WALK = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reprogram,
   input  logic [1:0] extTimeSelector,
   input  logic [3:0] extTimeValue,
   input  logic       start,
   input  logic [1:0] intervalSel,
   output logic       busy,
   output logic       expired,
   output logic [3:0] remaining
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      count, count_nxt;
   logic [PW-1:0]   presc, presc_nxt;
   logic [3:0]      slot0, slot1, slot2;
   logic [3:0]      load_val;
`ifdef WALK_SLOT_EN
   logic [3:0]      slot3;
`endif

   // Slot storage; a zero value is never written so a loaded count is always >= 1
   always_ff @(posedge clk) begin
      if (!reset) begin
         slot0 <= 4'(DEF_BASE);
         slot1 <= 4'(DEF_EXT);
         slot2 <= 4'(DEF_YEL);
`ifdef WALK_SLOT_EN
         slot3 <= 4'(DEF_WALK);
`endif
      end else if (reprogram && (extTimeValue != 4'd0)) begin
         case (extTimeSelector)
            2'd0:    slot0 <= extTimeValue;
            2'd1:    slot1 <= extTimeValue;
            2'd2:    slot2 <= extTimeValue;
`ifdef WALK_SLOT_EN
            2'd3:    slot3 <= extTimeValue;
`endif
            default: ;
         endcase
      end
   end

   // Reads pre-write slot contents, so a same-cycle reprogram only affects later starts
   always_comb begin
      load_val = slot0;
      case (intervalSel)
         2'd1:    load_val = slot1;
         2'd2:    load_val = slot2;
`ifdef WALK_SLOT_EN
         2'd3:    load_val = slot3;
`endif
         default: load_val = slot0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      presc_nxt = presc;
      if (start) begin
         state_nxt = RUN;
         count_nxt = load_val;
         presc_nxt = '0;
      end else begin
         case (state)
            RUN: begin
               if (presc == PW'(TICK_DIV - 1)) begin
                  presc_nxt = '0;
                  if (count == 4'd1) begin
                     state_nxt = EXPIRE;
                     count_nxt = 4'd0;
                  end else begin
                     count_nxt = count - 4'd1;
                  end
               end else begin
                  presc_nxt = presc + PW'(1);
               end
            end
            EXPIRE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered from next-state so they track the state register exactly
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= 4'd0;
         presc     <= '0;
         busy      <= 1'b0;
         expired   <= 1'b0;
         remaining <= 4'd0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         presc     <= presc_nxt;
         busy      <= (state_nxt == RUN);
         expired   <= (state_nxt == EXPIRE);
         remaining <= (state_nxt == RUN) ? count_nxt : 4'd0;
      end
   end

endmodule

// File: tb/tb_interval_timer_sched.sv
// Directed bench for interval_timer_sched with TICK_DIV=4 (one second = 4 clocks).
module tb_interval_timer_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       reprogram;
   logic [1:0] extTimeSelector;
   logic [3:0] extTimeValue;
   logic       start;
   logic [1:0] intervalSel;
   logic       busy;
   logic       expired;
   logic [3:0] remaining;

   int n_cmp  = 0;
   int n_fail = 0;

   interval_timer_sched #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .reprogram(reprogram),
      .extTimeSelector(extTimeSelector), .extTimeValue(extTimeValue),
      .start(start), .intervalSel(intervalSel),
      .busy(busy), .expired(expired), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] sel);
      start = 1'b1; intervalSel = sel;
      step();
      start = 1'b0;
   endtask

   // Observes win cycles: first cycle with expired high (-1 if none) and total pulses
   task automatic measure(input int win, output int lat, output int pulses);
      lat = -1; pulses = 0;
      for (int c = 1; c <= win; c++) begin
         step();
         if (expired) begin
            pulses++;
            if (lat < 0) lat = c;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b1; intervalSel = 2'd0;
      reprogram = 1'b1; extTimeSelector = 2'd0; extTimeValue = 4'd1;
      step(); step();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL reset_expired got %0b want 0", expired); end
      n_cmp++; if (remaining !== 4'd0) begin n_fail++; $display("FAIL reset_remaining got %0d want 0", remaining); end
      reset = 1'b1; start = 1'b0; reprogram = 1'b0; extTimeValue = 4'd0;
      step();
      n_cmp++; if (busy !== 1'b0 || remaining !== 4'd0) begin n_fail++; $display("FAIL post_reset_idle got busy=%0b rem=%0d want 0/0", busy, remaining); end
   endtask

   task automatic test_basic();
      int bad = 0;
      int lat, pulses;
      do_start(2'd2);
      n_cmp++; if (busy !== 1'b1 || remaining !== 4'd2) begin n_fail++; $display("FAIL basic_first got busy=%0b rem=%0d want 1/2", busy, remaining); end
      for (int i = 1; i < 8; i++) begin
         step();
         if (busy !== 1'b1 || expired !== 1'b0 || remaining !== ((i < 4) ? 4'd2 : 4'd1)) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL basic_countdown got %0d bad cycles want 0", bad); end
      step();
      n_cmp++; if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin n_fail++; $display("FAIL basic_expire got exp=%0b busy=%0b rem=%0d want 1/0/0", expired, busy, remaining); end
      measure(6, lat, pulses);
      n_cmp++; if (pulses != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got pulses=%0d busy=%0b want 0/0", pulses, busy); end
   endtask

   task automatic test_restart();
      int lat, pulses;
      do_start(2'd0);
      measure(9, lat, pulses);
      start = 1'b1; intervalSel = 2'd1;
      step();
      start = 1'b0;
      n_cmp++; if (remaining !== 4'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_reload got rem=%0d busy=%0b want 3/1", remaining, busy); end
      n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL restart_early_pulse got %0d want 0", pulses); end
      measure(30, lat, pulses);
      n_cmp++; if (lat != 12) begin n_fail++; $display("FAIL restart_latency got %0d want 12", lat); end
      n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL restart_pulses got %0d want 1", pulses); end
   endtask

   task automatic test_same_cycle();
      int lat, pulses;
      start = 1'b1; intervalSel = 2'd1;
      reprogram = 1'b1; extTimeSelector = 2'd1; extTimeValue = 4'd7;
      step();
      start = 1'b0; reprogram = 1'b0;
      n_cmp++; if (remaining !== 4'd3) begin n_fail++; $display("FAIL same_cycle_old got %0d want 3", remaining); end
      measure(16, lat, pulses);
      n_cmp++; if (lat != 12) begin n_fail++; $display("FAIL same_cycle_latency got %0d want 12", lat); end
      do_start(2'd1);
      n_cmp++; if (remaining !== 4'd7) begin n_fail++; $display("FAIL same_cycle_new got %0d want 7", remaining); end
      measure(32, lat, pulses);
      n_cmp++; if (lat != 28) begin n_fail++; $display("FAIL same_cycle_new_latency got %0d want 28", lat); end
   endtask

   task automatic test_reprogram();
      int lat, pulses;
      reprogram = 1'b1; extTimeSelector = 2'd0; extTimeValue = 4'd9;
      step();
      reprogram = 1'b0;
      do_start(2'd0);
      reprogram = 1'b1; extTimeValue = 4'd0;
      step();
      reprogram = 1'b0;
      measure(40, lat, pulses);
      n_cmp++; if (lat != 35) begin n_fail++; $display("FAIL reprog_9s got %0d want 35 (+1)", lat); end
      do_start(2'd0);
      n_cmp++; if (remaining !== 4'd9) begin n_fail++; $display("FAIL reprog_zero_ignored got %0d want 9", remaining); end
      reprogram = 1'b1; extTimeValue = 4'd2;
      step();
      reprogram = 1'b0;
      measure(40, lat, pulses);
      n_cmp++; if (lat != 35) begin n_fail++; $display("FAIL reprog_midrun_stable got %0d want 35 (+1)", lat); end
      do_start(2'd0);
      measure(12, lat, pulses);
      n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL reprog_next_start got %0d want 8", lat); end
   endtask

   task automatic test_reset_midrun();
      int lat, pulses;
      do_start(2'd0);
      measure(3, lat, pulses);
      reset = 1'b0;
      step();
      reset = 1'b1;
      n_cmp++; if (busy !== 1'b0 || remaining !== 4'd0 || expired !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got busy=%0b rem=%0d exp=%0b want 0/0/0", busy, remaining, expired); end
      measure(20, lat, pulses);
      n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL midrun_no_pulse got %0d want 0", pulses); end
      do_start(2'd0);
      n_cmp++; if (remaining !== 4'd6) begin n_fail++; $display("FAIL default_base got %0d want 6", remaining); end
      measure(28, lat, pulses);
      n_cmp++; if (lat != 24) begin n_fail++; $display("FAIL default_base_latency got %0d want 24", lat); end
      do_start(2'd1);
      n_cmp++; if (remaining !== 4'd3) begin n_fail++; $display("FAIL default_ext got %0d want 3", remaining); end
      measure(16, lat, pulses);
   endtask

   task automatic test_walk_slot();
      int lat, pulses;
      int exp_s;
`ifdef WALK_SLOT_EN
      exp_s = 5;
`else
      exp_s = 6;
`endif
      reprogram = 1'b1; extTimeSelector = 2'd3; extTimeValue = 4'd5;
      step();
      reprogram = 1'b0;
      do_start(2'd3);
      n_cmp++; if (remaining !== 4'(exp_s)) begin n_fail++; $display("FAIL walk_slot_load got %0d want %0d", remaining, exp_s); end
      measure(30, lat, pulses);
      n_cmp++; if (lat != exp_s * 4) begin n_fail++; $display("FAIL walk_slot_latency got %0d want %0d", lat, exp_s * 4); end
   endtask

   initial begin
      reset = 1'b0; reprogram = 1'b0; extTimeSelector = 2'd0; extTimeValue = 4'd0;
      start = 1'b0; intervalSel = 2'd0;
      step();
      test_reset();
      test_basic();
      test_restart();
      test_same_cycle();
      test_reprogram();
      test_reset_midrun();
      test_walk_slot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
